pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard controller for the pipelined MIPS core, sitting between the IF/ID and ID/EX pipeline registers. It detects load-use hazards and RAW/WAW hazards against long-latency multi-cycle operations, the latter tracked in an internal countdown scoreboard. It stalls PC and IF/ID and injects ID/EX bubbles on any hazard. It also flushes on taken branches and stalls issue when the scoreboard is full.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- SB_DEPTH, 4, scoreboard entries (long ops in flight)
- LAT_W, 4, width of latency field/countdown

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  REG_ADDR_W  ID source registers
- id_rs_used, id_rt_used  in  1  source actually read
- id_long  in  1  ID instruction is a multi-cycle op
- id_dest  in  REG_ADDR_W  long-op destination
- id_lat  in  LAT_W  cycles until long-op result is readable
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  REG_ADDR_W  load destination in EX
- branch_taken  in  1  branch resolved taken in EX
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- id_ex_cancel  out  1  zero ID/EX control (bubble)
- if_id_flush  out  1  clear IF/ID
- sb_full  out  1  all scoreboard entries valid
- stall_cycles  out  32  stall count (only with HAZARD_PERF_CNT_EN)

## Operation
- Register 0 never causes a hazard, is never allocated, and never matches.
- lu = ex_mem_read && ex_rt!=0 && ((id_rs_used && id_rs==ex_rt) || (id_rt_used && id_rt==ex_rt)).
- sb = any valid entry whose reg matches a used source (RAW), or matches id_dest when id_long (WAW).
- st = id_long && sb_full; sb_full is taken from registered state, with no same-cycle free bypass.
- stall = id_valid && !branch_taken && (lu || sb || st).
- Stall: pc_write=0, if_id_write=0, id_ex_cancel=1, if_id_flush=0.
- branch_taken takes priority over stall: if_id_flush=1, id_ex_cancel=1, pc_write=1, if_id_write=1. No allocation occurs that cycle.
- Otherwise: pc_write=1, if_id_write=1, id_ex_cancel=0, if_id_flush=0.
- Allocate when id_valid && id_long && !stall && !branch_taken && id_dest!=0 && id_lat!=0. The lowest-index free entry gets {valid=1, reg=id_dest, cnt=id_lat}. id_lat==0 allocates nothing.
- Each edge, every valid entry with cnt>1 decrements. An entry with cnt==1 is cleared. Allocation and clearing of different entries in the same edge are both honoured.
- Reset: all entries invalid, sb_full=0, stall_cycles=0. While rst=1 the outputs are forced to pc_write=1, if_id_write=1, id_ex_cancel=0, if_id_flush=0.

## Timing
- All control outputs are combinational from the inputs and registered scoreboard state, valid in the same cycle.
- The scoreboard updates on the rising clk edge.
- An entry allocated at edge E with latency L blocks dependents for exactly L cycles after E.
- Load-use stall lasts exactly one cycle: the load leaves EX and ex_mem_read drops.
- Reset asserted mid-operation discards all in-flight entries at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cycles port and a 32-bit counter exist. The counter increments each cycle stall=1 and saturates at 0xFFFFFFFF.
- HAZARD_PERF_CNT_EN undefined: no port and no counter logic.

## Structure
- Package hazard_pkg holds the default REG_ADDR_W/LAT_W constants and typedef sb_entry_t {valid, reg, cnt}.
- Sub-module hazard_scoreboard holds the entry array, allocation, countdown, match vector and sb_full. The top level holds hazard combination, output priority and the perf counter.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 used -> one cycle with pc_write=0, if_id_write=0, id_ex_cancel=1; next cycle all clear.
- Register 0: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall.
- Long op: allocate dest=9, lat=3; following instruction reads r9 -> stalled exactly 3 cycles, then issues.
- Full: SB_DEPTH=4, four long ops lat=15 in flight -> sb_full=1; a fifth long op stalls until the first entry clears.
- Branch priority: branch_taken=1 with lu=1 -> if_id_flush=1, id_ex_cancel=1, pc_write=1, no allocation.
- Reset mid-flight: rst during active entries -> sb_full=0, a dependent issues without stall; with HAZARD_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared defaults and scoreboard entry layout for the hazard controller.
// Combinational-only package; no latency or backpressure of its own.
package hazard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int LAT_W_DEF      = 4;
  localparam int SB_DEPTH_DEF   = 4;

  // Entry at default widths; 'dst' holds the destination register.
  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] dst;
    logic [LAT_W_DEF-1:0]      cnt;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Countdown scoreboard of long-latency destinations; hit/full are combinational from state.
// Updates each edge; the caller must only raise alloc when full is low.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SB_DEPTH   = SB_DEPTH_DEF,
  parameter int LAT_W      = LAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc,
  input  logic [REG_ADDR_W-1:0] alloc_reg,
  input  logic [LAT_W-1:0]      alloc_lat,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  rs_used,
  input  logic                  rt_used,
  input  logic                  chk_dest,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  hit,
  output logic                  full
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic [LAT_W-1:0]      cnt;
  } entry_t;

  entry_t [SB_DEPTH-1:0] sb_q;
  logic   [SB_DEPTH-1:0] alloc_oh;
  logic   [SB_DEPTH-1:0] valid_vec;
  logic   [SB_DEPTH-1:0] hit_vec;
  logic                  found;

  always_comb begin
    alloc_oh  = '0;
    valid_vec = '0;
    hit_vec   = '0;
    found     = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      valid_vec[i] = sb_q[i].valid;
      if (!sb_q[i].valid && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
      hit_vec[i] = sb_q[i].valid &&
                   ((rs_used  && rs   != '0 && sb_q[i].dst == rs) ||
                    (rt_used  && rt   != '0 && sb_q[i].dst == rt) ||
                    (chk_dest && dest != '0 && sb_q[i].dst == dest));
    end
  end

  assign hit  = |hit_vec;
  assign full = &valid_vec;

  // Allocation only targets free slots, so it never collides with a countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (alloc && alloc_oh[i]) begin
          sb_q[i].valid <= 1'b1;
          sb_q[i].dst   <= alloc_reg;
          sb_q[i].cnt   <= alloc_lat;
        end else if (sb_q[i].valid) begin
          if (sb_q[i].cnt == LAT_W'(1)) sb_q[i] <= '0;
          else                          sb_q[i].cnt <= sb_q[i].cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / long-op hazard stall, branch flush; outputs combinational, same cycle. Stall holds PC+IF/ID.
// Optional stall counter under HAZARD_PERF_CNT_EN; scoreboard full stalls long-op issue.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SB_DEPTH   = SB_DEPTH_DEF,
  parameter int LAT_W      = LAT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic                  id_long,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_cancel,
  output logic                  if_id_flush,
  output logic                  sb_full
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic lu, sb_hit, st, stall, alloc;

  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((id_rs_used && id_rs == ex_rt) || (id_rt_used && id_rt == ex_rt));
  assign st    = id_long && sb_full;
  assign stall = id_valid && !branch_taken && (lu || sb_hit || st);
  assign alloc = !rst && id_valid && id_long && !stall && !branch_taken &&
                 (id_dest != '0) && (id_lat != '0);

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .SB_DEPTH   (SB_DEPTH),
    .LAT_W      (LAT_W)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .alloc     (alloc),
    .alloc_reg (id_dest),
    .alloc_lat (id_lat),
    .rs        (id_rs),
    .rt        (id_rt),
    .rs_used   (id_rs_used),
    .rt_used   (id_rt_used),
    .chk_dest  (id_long),
    .dest      (id_dest),
    .hit       (sb_hit),
    .full      (sb_full)
  );

  // Branch flush outranks stall; reset forces the free-running pattern.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_cancel = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst) begin
      if (branch_taken) begin
        id_ex_cancel = 1'b1;
        if_id_flush  = 1'b1;
      end else if (stall) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_cancel = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                   stall_cycles <= '0;
    else if (stall && stall_cycles != '1)      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomised + directed bench for pipeline_hazard_ctrl with an in-flight-list reference model.
// Driver pushes expected outputs per cycle; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_rs_used, id_rt_used, id_long, ex_mem_read, branch_taken;
  logic [4:0]  id_rs, id_rt, id_dest, ex_rt;
  logic [3:0]  id_lat;
  logic        pc_write, if_id_write, id_ex_cancel, if_id_flush, sb_full;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .SB_DEPTH(D), .LAT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .id_long      (id_long),
    .id_dest      (id_dest),
    .id_lat       (id_lat),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .id_ex_cancel (id_ex_cancel),
    .if_id_flush  (if_id_flush),
    .sb_full      (sb_full)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  typedef struct {
    bit       rst, valid, rs_used, rt_used, lng, mem_read, br;
    bit [4:0] rs, rt, dest, ex_rt;
    bit [3:0] lat;
  } in_t;

  typedef struct {
    bit        pcw, ifw, cancel, flush, full;
    bit [31:0] perf;
  } exp_t;

  typedef struct {
    bit [4:0]    r;
    int unsigned expiry;
  } fl_t;

  exp_t        expq[$];
  fl_t         inflight[$];
  int unsigned cyc;
  bit          p_rst, p_alloc, p_stall, exp_stall;
  bit [4:0]    p_dest;
  bit [3:0]    p_lat;
  bit [31:0]   perf_m;
  int          n_checks, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit busy(input bit [4:0] r);
    if (r == 0) return 1'b0;
    foreach (inflight[i]) if (inflight[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic in_t nop();
    in_t s;
    s = '{default: 0};
    return s;
  endfunction

  // One clock: retire the previous cycle into the model, drive s, predict the outputs.
  task automatic cycle(input in_t s);
    bit   lu, hz, full, stall;
    exp_t e;
    @(posedge clk);
    cyc++;
    if (p_rst) begin
      inflight.delete();
      perf_m = 0;
    end else begin
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].expiry <= cyc) inflight.delete(i);
      if (p_alloc) inflight.push_back('{p_dest, cyc + p_lat});
      if (p_stall && perf_m != 32'hFFFF_FFFF) perf_m++;
    end
    #1;
    rst = s.rst; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
    id_rs_used = s.rs_used; id_rt_used = s.rt_used; id_long = s.lng;
    id_dest = s.dest; id_lat = s.lat; ex_mem_read = s.mem_read;
    ex_rt = s.ex_rt; branch_taken = s.br;

    lu    = s.mem_read && s.ex_rt != 0 &&
            ((s.rs_used && s.rs == s.ex_rt) || (s.rt_used && s.rt == s.ex_rt));
    hz    = (s.rs_used && busy(s.rs)) || (s.rt_used && busy(s.rt)) || (s.lng && busy(s.dest));
    full  = inflight.size() >= D;
    stall = !s.rst && s.valid && !s.br && (lu || hz || (s.lng && full));

    e.full = full;
    e.perf = perf_m;
    if (s.rst)       begin e.pcw = 1; e.ifw = 1; e.cancel = 0; e.flush = 0; end
    else if (s.br)   begin e.pcw = 1; e.ifw = 1; e.cancel = 1; e.flush = 1; end
    else if (stall)  begin e.pcw = 0; e.ifw = 0; e.cancel = 1; e.flush = 0; end
    else             begin e.pcw = 1; e.ifw = 1; e.cancel = 0; e.flush = 0; end
    expq.push_back(e);

    exp_stall = stall;
    p_rst     = s.rst;
    p_stall   = stall;
    p_alloc   = !s.rst && s.valid && s.lng && !stall && !s.br && s.dest != 0 && s.lat != 0;
    p_dest    = s.dest;
    p_lat     = s.lat;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("pc_write",     32'(pc_write),     32'(e.pcw));
        check("if_id_write",  32'(if_id_write),  32'(e.ifw));
        check("id_ex_cancel", 32'(id_ex_cancel), 32'(e.cancel));
        check("if_id_flush",  32'(if_id_flush),  32'(e.flush));
        check("sb_full",      32'(sb_full),      32'(e.full));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles", stall_cycles,      e.perf);
`endif
      end
    end
  end

  initial begin : driver
    in_t s, r;
    int  n;
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_long = 0; id_dest = 0; id_lat = 0; ex_mem_read = 0; ex_rt = 0; branch_taken = 0;
    cyc = 0; p_rst = 1; p_alloc = 0; p_stall = 0; perf_m = 0;
    n_checks = 0; n_fail = 0;

    s = nop(); s.rst = 1;
    cycle(s); cycle(s);
    cycle(nop());

    // load-use on r8: one stall, then clear once the load leaves EX
    s = nop(); s.valid = 1; s.rs = 8; s.rs_used = 1; s.mem_read = 1; s.ex_rt = 8;
    cycle(s);
    s.mem_read = 0;
    cycle(s);

    // r0 never hazards
    s = nop(); s.valid = 1; s.rs = 0; s.rs_used = 1; s.mem_read = 1; s.ex_rt = 0;
    cycle(s);

    // branch beats load-use and suppresses allocation of r6
    s = nop(); s.valid = 1; s.rs = 8; s.rs_used = 1; s.mem_read = 1; s.ex_rt = 8;
    s.br = 1; s.lng = 1; s.dest = 6; s.lat = 5;
    cycle(s);
    r = nop(); r.valid = 1; r.rs = 6; r.rs_used = 1;
    cycle(r);
    #2 check("branch_no_alloc", 32'(pc_write), 32'd1);

    // long op r9, lat 3; dependent must wait exactly 3 cycles
    s = nop(); s.valid = 1; s.lng = 1; s.dest = 9; s.lat = 3;
    cycle(s);
    r = nop(); r.valid = 1; r.rt = 9; r.rt_used = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(r);
      #2 if (pc_write === 1'b0) n++;
      if (!exp_stall) break;
    end
    check("raw_stall_len", n, 3);
    cycle(nop());

    // four lat-15 ops fill the scoreboard; a fifth waits for the first to retire
    for (int k = 1; k <= 4; k++) begin
      s = nop(); s.valid = 1; s.lng = 1; s.dest = 5'(k); s.lat = 15;
      cycle(s);
    end
    s = nop(); s.valid = 1; s.lng = 1; s.dest = 5; s.lat = 15;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(s);
      #2 if (pc_write === 1'b0) n++;
      if (!exp_stall) break;
    end
    check("full_stall_len", n, 12);

    // reset mid-flight discards r2..r5
    s = nop(); s.rst = 1;
    cycle(s);
    r = nop(); r.valid = 1; r.rs = 2; r.rs_used = 1;
    cycle(r);
    #2 begin
      check("rst_dep_issue", 32'(pc_write), 32'd1);
      check("rst_sb_full",   32'(sb_full),  32'd0);
    end

    for (int i = 0; i < 3000; i++) begin
      s = nop();
      s.rst      = ($urandom_range(0, 63) == 0);
      s.valid    = ($urandom_range(0, 9) != 0);
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.rs_used  = 1'($urandom);
      s.rt_used  = 1'($urandom);
      s.lng      = ($urandom_range(0, 9) < 3);
      s.dest     = 5'($urandom_range(0, 7));
      s.lat      = 4'($urandom_range(0, 15));
      s.mem_read = ($urandom_range(0, 9) < 3);
      s.ex_rt    = 5'($urandom_range(0, 7));
      s.br       = ($urandom_range(0, 9) == 0);
      cycle(s);
    end
    cycle(nop());

    n = 0;
    while (expq.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) check("drain", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
